pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Parametrised pipeline controller for the rua core, generalising the fixed pause/flush arbiter to STAGES stages with per-stage enable, flush and bubble outputs. It adds three things: a load-use scoreboard that raises the decode stall internally, an outstanding-load limiter, and a stall watchdog. It sits beside the ifu/id/ex/mem stages and drives the pldff enables and resets between them.

Parameters:
STAGES, 4, number of pipeline stages; index 0 = fetch (youngest), STAGES-1 = oldest
REG_AW, 5, register address width; REGS = 2**REG_AW scoreboard entries
DECODE_STAGE, 1, stage that receives the scoreboard hazard stall
EXEC_STAGE, 2, stage that receives the outstanding-load stall
MAX_OUT, 2, maximum outstanding loads (>=1)
TIMEOUT, 255, cycles of frozen fetch before the watchdog trips (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
pause_req  in  STAGES  per-stage stall request
flush_req  in  STAGES  bit k set: flush all stages younger than k
rs1_addr  in  REG_AW  decode source 1
rs1_use  in  1  source 1 read by decode instruction
rs2_addr  in  REG_AW  decode source 2
rs2_use  in  1  source 2 read by decode instruction
load_issue  in  1  load leaves EXEC_STAGE this cycle (already qualified by producer)
load_rd  in  REG_AW  destination of issued load
load_done  in  1  mem writes back a loaded value
load_done_rd  in  REG_AW  destination of returning load
stage_en  out  STAGES  stage register may capture
stage_flush  out  STAGES  stage register loads NOP/0
bubble  out  STAGES  stage receives a bubble (younger stage stalled)
hazard  out  1  scoreboard load-use stall active
load_block  out  1  outstanding count == MAX_OUT
pending  out  REGS  scoreboard bits
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Combinational: pause_eff = pause_req | (hazard << DECODE_STAGE) | (load_block << EXEC_STAGE).
- Flush: stage_flush[i] = OR of flush_req[j] for j > i. A flushed stage ignores its own pause_eff bit.
- Stall propagation: stage_en[i] = ~|(pause_eff & ~stage_flush)[STAGES-1:i]. A stall freezes its stage and all younger stages; older stages keep advancing.
- bubble[i+1] = stage_en[i+1] & ~stage_en[i]; bubble[0] = 0.
- Hazard: hazard = (rs1_use & rs1_addr != 0 & pending[rs1_addr] & ~(load_done & load_done_rd == rs1_addr)) | (the same term for rs2). Writeback in the same cycle bypasses the stall.
- Scoreboard (posedge, async rst clears all bits):
  - load_issue & load_rd != 0 & ~load_block sets pending[load_rd].
  - load_done clears pending[load_done_rd].
  - Set and clear of the same rd in one cycle: set wins.
  - pending[0] is always 0.
- Outstanding counter, width $clog2(MAX_OUT+1):
  - +1 on accepted issue, -1 on load_done, unchanged when both occur.
  - Never exceeds MAX_OUT; an issue while load_block is dropped.
  - load_done at count 0 leaves the count at 0.
  - load_block = (count == MAX_OUT).
- Flush does not alter the scoreboard or the counter; in-flight loads still complete.
- Watchdog:
  - Timer increments while stage_en[0] == 0, clears when stage_en[0] == 1, saturates at TIMEOUT.
  - Reaching TIMEOUT sets stall_timeout, which only rst clears.
- Reset values: pending = 0, count = 0, timer = 0, stall_timeout = 0. While rst is high, stage_en = 0 and stage_flush = all 1s; hazard and load_block evaluate to 0 because the registers are cleared.
- Reset asserted mid-operation discards all outstanding state immediately.

Optional Feature:
PIPE_CTRL_PERF_EN:
- Defined: adds outputs perf_stall_cycles (32) and perf_flush_events (32).
  - perf_stall_cycles increments each cycle ~stage_en[0] is high outside reset.
  - perf_flush_events increments each cycle |flush_req is high.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package/define file: stage index constants (STAGE_IF, STAGE_ID, STAGE_EX, STAGE_MEM), REG_AW default, NOP encoding.
- Sub-module pipe_scoreboard: pending bits, outstanding counter, hazard compare. pipe_ctrl keeps stall/flush/bubble logic and the watchdog.

Test Plan:
- Reset, then pause_req=4'b0100 -> stage_en=4'b1000, bubble=4'b1000, stage_flush=0.
- flush_req=4'b0100 with pause_req=4'b0011 -> stage_flush=4'b0011, stage_en=4'b1111.
- load_issue rd=5; next cycle rs1_use, rs1_addr=5 -> hazard=1, stage_en=4'b1100. load_done rd=5 that cycle -> hazard=0. Next cycle pending[5]=0.
- Same cycle load_done rd=7 and load_issue rd=7 (pending[7] already set) -> pending[7] stays 1, count unchanged.
- Two issues (rd 3, 4) with MAX_OUT=2 -> load_block=1, stage_en[2:0]=0. A third issue rd=6 is dropped: pending[6]=0. One load_done -> load_block=0.
- Hold pause_req[0]=1 for 255 cycles with TIMEOUT=255 -> stall_timeout=1 and stays 1 after release; rst clears it. With PIPE_CTRL_PERF_EN, perf_stall_cycles=255.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the rua pipeline controller: stage indices, default
// register address width and the NOP encoding loaded by a flushed stage.
package pipe_ctrl_pkg;

    localparam int STAGE_IF  = 0;
    localparam int STAGE_ID  = 1;
    localparam int STAGE_EX  = 2;
    localparam int STAGE_MEM = 3;

    localparam int REG_AW_DEFAULT = 5;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and pipe_ctrl.
// PIPE_CTRL_PERF_EN adds the two performance counter outputs.
interface pipe_ctrl_if #(
    parameter int STAGES = 4,
    parameter int REG_AW = 5
);
    localparam int REGS = 2 ** REG_AW;

    logic [STAGES-1:0] pause_req;
    logic [STAGES-1:0] flush_req;
    logic [REG_AW-1:0] rs1_addr;
    logic              rs1_use;
    logic [REG_AW-1:0] rs2_addr;
    logic              rs2_use;
    logic              load_issue;
    logic [REG_AW-1:0] load_rd;
    logic              load_done;
    logic [REG_AW-1:0] load_done_rd;

    logic [STAGES-1:0] stage_en;
    logic [STAGES-1:0] stage_flush;
    logic [STAGES-1:0] bubble;
    logic              hazard;
    logic              load_block;
    logic [REGS-1:0]   pending;
    logic              stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]       perf_stall_cycles;
    logic [31:0]       perf_flush_events;

    modport master (
        output pause_req, flush_req, rs1_addr, rs1_use, rs2_addr, rs2_use,
               load_issue, load_rd, load_done, load_done_rd,
        input  stage_en, stage_flush, bubble, hazard, load_block, pending,
               stall_timeout, perf_stall_cycles, perf_flush_events
    );
    modport slave (
        input  pause_req, flush_req, rs1_addr, rs1_use, rs2_addr, rs2_use,
               load_issue, load_rd, load_done, load_done_rd,
        output stage_en, stage_flush, bubble, hazard, load_block, pending,
               stall_timeout, perf_stall_cycles, perf_flush_events
    );
`else
    modport master (
        output pause_req, flush_req, rs1_addr, rs1_use, rs2_addr, rs2_use,
               load_issue, load_rd, load_done, load_done_rd,
        input  stage_en, stage_flush, bubble, hazard, load_block, pending,
               stall_timeout
    );
    modport slave (
        input  pause_req, flush_req, rs1_addr, rs1_use, rs2_addr, rs2_use,
               load_issue, load_rd, load_done, load_done_rd,
        output stage_en, stage_flush, bubble, hazard, load_block, pending,
               stall_timeout
    );
`endif

endinterface

// File: rtl/pipe_scoreboard.sv
// Load-use scoreboard: one pending bit per register, an outstanding-load
// counter that limits in-flight loads, and the decode hazard compare.
module pipe_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEFAULT,
    parameter int MAX_OUT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_AW-1:0]    rs1_addr,
    input  logic                 rs1_use,
    input  logic [REG_AW-1:0]    rs2_addr,
    input  logic                 rs2_use,
    input  logic                 load_issue,
    input  logic [REG_AW-1:0]    load_rd,
    input  logic                 load_done,
    input  logic [REG_AW-1:0]    load_done_rd,
    output logic                 hazard,
    output logic                 load_block,
    output logic [2**REG_AW-1:0] pending
);
    localparam int REGS = 2 ** REG_AW;
    localparam int CW   = $clog2(MAX_OUT + 1);

    logic [REGS-1:0]   pending_q, pending_d;
    logic [CW-1:0]     count_q, count_d;
    logic              issue_ok;
    logic [REG_AW-1:0] src_addr [2];
    logic [1:0]        src_use;
    logic [1:0]        src_hit;

    assign load_block = (count_q == CW'(MAX_OUT));
    assign issue_ok   = load_issue & ~load_block;
    assign pending    = pending_q;

    assign src_addr[0] = rs1_addr;
    assign src_addr[1] = rs2_addr;
    assign src_use     = {rs2_use, rs1_use};

    // A load writing back this cycle forwards its value, so it does not stall.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign src_hit[gi] = src_use[gi] & (src_addr[gi] != '0) & pending_q[src_addr[gi]]
                           & ~(load_done & (load_done_rd == src_addr[gi]));
    end
    assign hazard = |src_hit;

    always_comb begin
        pending_d = pending_q;
        if (load_done) begin
            pending_d[load_done_rd] = 1'b0;
        end
        // Applied after the clear so a re-issue to the same rd stays pending.
        if (issue_ok && (load_rd != '0)) begin
            pending_d[load_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        count_d = count_q;
        case ({issue_ok, load_done})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = (count_q == '0) ? '0 : count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage enable/flush/bubble, scoreboard-driven stalls
// and a fetch-stall watchdog. Define PIPE_CTRL_PERF_EN for perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES       = 4,
    parameter int REG_AW       = REG_AW_DEFAULT,
    parameter int DECODE_STAGE = STAGE_ID,
    parameter int EXEC_STAGE   = STAGE_EX,
    parameter int MAX_OUT      = 2,
    parameter int TIMEOUT      = 255
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic              hazard;
    logic              load_block;
    logic [STAGES-1:0] pause_eff;
    logic [STAGES-1:0] flush_raw;
    logic [STAGES-1:0] stall_mask;
    logic [STAGES-1:0] en_raw;
    logic [STAGES-1:0] stage_en;
    logic [TW-1:0]     timer_q, timer_d;
    logic              stall_timeout_q, stall_timeout_d;

    pipe_scoreboard #(
        .REG_AW  (REG_AW),
        .MAX_OUT (MAX_OUT)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .rs1_addr     (bus.rs1_addr),
        .rs1_use      (bus.rs1_use),
        .rs2_addr     (bus.rs2_addr),
        .rs2_use      (bus.rs2_use),
        .load_issue   (bus.load_issue),
        .load_rd      (bus.load_rd),
        .load_done    (bus.load_done),
        .load_done_rd (bus.load_done_rd),
        .hazard       (hazard),
        .load_block   (load_block),
        .pending      (bus.pending)
    );

    assign pause_eff = bus.pause_req
                     | (STAGES'(hazard) << DECODE_STAGE)
                     | (STAGES'(load_block) << EXEC_STAGE);

    // A flushed stage's own stall is irrelevant: its contents are being discarded.
    assign stall_mask = pause_eff & ~flush_raw;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == STAGES - 1) begin : g_oldest
            assign flush_raw[gi] = 1'b0;
        end else begin : g_younger
            assign flush_raw[gi] = |bus.flush_req[STAGES-1:gi+1];
        end
        assign en_raw[gi] = ~|stall_mask[STAGES-1:gi];
        if (gi == 0) begin : g_fetch
            assign bus.bubble[gi] = 1'b0;
        end else begin : g_bubble
            assign bus.bubble[gi] = stage_en[gi] & ~stage_en[gi-1];
        end
    end

    assign stage_en        = rst ? '0 : en_raw;
    assign bus.stage_en    = stage_en;
    assign bus.stage_flush = rst ? '1 : flush_raw;
    assign bus.hazard      = hazard;
    assign bus.load_block  = load_block;
    assign bus.stall_timeout = stall_timeout_q;

    always_comb begin
        timer_d = timer_q;
        if (stage_en[0]) begin
            timer_d = '0;
        end else if (timer_q != TW'(TIMEOUT)) begin
            timer_d = timer_q + TW'(1);
        end
        stall_timeout_d = stall_timeout_q | (timer_d == TW'(TIMEOUT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q         <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            timer_q         <= timer_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + (stage_en[0] ? 32'd0 : 32'd1);
        perf_flush_d = perf_flush_q + ((|bus.flush_req) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign bus.perf_stall_cycles = perf_stall_q;
    assign bus.perf_flush_events = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the controller.
module tb_pipe_ctrl;
    localparam int ST   = 4;
    localparam int AW   = 5;
    localparam int DEC  = 1;
    localparam int EXE  = 2;
    localparam int MAXO = 2;
    localparam int TO   = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.STAGES(ST), .REG_AW(AW)) bus ();

    pipe_ctrl #(
        .STAGES(ST), .REG_AW(AW), .DECODE_STAGE(DEC), .EXEC_STAGE(EXE),
        .MAX_OUT(MAXO), .TIMEOUT(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural model state
    bit [31:0]   m_pend;
    int          m_count;
    int          m_timer;
    bit          m_to;
    int unsigned m_perf_stall;
    int unsigned m_perf_flush;

    function automatic void model_reset();
        m_pend = '0; m_count = 0; m_timer = 0; m_to = 1'b0;
        m_perf_stall = 0; m_perf_flush = 0;
    endfunction

    function automatic void model_comb(output logic [3:0] en, output logic [3:0] fl,
                                       output logic [3:0] bub, output logic haz,
                                       output logic blk);
        logic [3:0] eff;
        haz = 1'b0;
        if (bus.rs1_use && bus.rs1_addr != 0 && m_pend[bus.rs1_addr] &&
            !(bus.load_done && bus.load_done_rd == bus.rs1_addr)) haz = 1'b1;
        if (bus.rs2_use && bus.rs2_addr != 0 && m_pend[bus.rs2_addr] &&
            !(bus.load_done && bus.load_done_rd == bus.rs2_addr)) haz = 1'b1;
        blk = (m_count == MAXO);
        eff = bus.pause_req;
        if (haz) eff[DEC] = 1'b1;
        if (blk) eff[EXE] = 1'b1;
        for (int i = 0; i < ST; i++) begin
            fl[i] = 1'b0;
            for (int j = i + 1; j < ST; j++) if (bus.flush_req[j]) fl[i] = 1'b1;
        end
        for (int i = 0; i < ST; i++) begin
            en[i] = 1'b1;
            for (int j = i; j < ST; j++) if (eff[j] && !fl[j]) en[i] = 1'b0;
        end
        if (rst) begin
            en = '0; fl = '1;
        end
        bub = '0;
        for (int i = 1; i < ST; i++) bub[i] = en[i] && !en[i-1];
    endfunction

    function automatic void model_update();
        logic [3:0] en, fl, bub;
        logic haz, blk, accept;
        model_comb(en, fl, bub, haz, blk);
        accept = bus.load_issue && !blk;
        if (bus.load_done) m_pend[bus.load_done_rd] = 1'b0;
        if (accept && bus.load_rd != 0) m_pend[bus.load_rd] = 1'b1;
        if (accept && !bus.load_done) m_count++;
        else if (!accept && bus.load_done && m_count > 0) m_count--;
        if (!en[0]) begin
            if (m_timer < TO) m_timer++;
        end else begin
            m_timer = 0;
        end
        if (m_timer == TO) m_to = 1'b1;
        if (!en[0]) m_perf_stall++;
        if (|bus.flush_req) m_perf_flush++;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) model_update();
        #1;
    endtask

    task automatic clear_inputs();
        bus.pause_req = '0; bus.flush_req = '0;
        bus.rs1_addr = '0; bus.rs1_use = 1'b0; bus.rs2_addr = '0; bus.rs2_use = 1'b0;
        bus.load_issue = 1'b0; bus.load_rd = '0; bus.load_done = 1'b0; bus.load_done_rd = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        model_reset();
        #1;
        checks += 7;
        if (bus.stage_en !== 4'b0000) begin errors++; $display("FAIL reset_en got %b want 0000", bus.stage_en); end
        if (bus.stage_flush !== 4'b1111) begin errors++; $display("FAIL reset_flush got %b want 1111", bus.stage_flush); end
        if (bus.bubble !== 4'b0000) begin errors++; $display("FAIL reset_bubble got %b want 0000", bus.bubble); end
        if (bus.hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b want 0", bus.hazard); end
        if (bus.load_block !== 1'b0) begin errors++; $display("FAIL reset_load_block got %b want 0", bus.load_block); end
        if (bus.pending !== 32'h0) begin errors++; $display("FAIL reset_pending got %h want 0", bus.pending); end
        if (bus.stall_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", bus.stall_timeout); end
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (bus.perf_stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_perf got %0d want 0", bus.perf_stall_cycles); end
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_stall_flush();
        clear_inputs();
        bus.pause_req = 4'b0100;
        @(negedge clk);
        checks += 3;
        if (bus.stage_en !== 4'b1000) begin errors++; $display("FAIL pause_en got %b want 1000", bus.stage_en); end
        if (bus.bubble !== 4'b1000) begin errors++; $display("FAIL pause_bubble got %b want 1000", bus.bubble); end
        if (bus.stage_flush !== 4'b0000) begin errors++; $display("FAIL pause_flush got %b want 0000", bus.stage_flush); end
        tick();
        bus.pause_req = 4'b0011; bus.flush_req = 4'b0100;
        @(negedge clk);
        checks += 3;
        if (bus.stage_flush !== 4'b0011) begin errors++; $display("FAIL flush_flush got %b want 0011", bus.stage_flush); end
        if (bus.stage_en !== 4'b1111) begin errors++; $display("FAIL flush_en got %b want 1111", bus.stage_en); end
        if (bus.bubble !== 4'b0000) begin errors++; $display("FAIL flush_bubble got %b want 0000", bus.bubble); end
        tick();
        clear_inputs();
        tick();
        $display("test_stall_flush done");
    endtask

    task automatic test_load_use();
        clear_inputs();
        bus.load_issue = 1'b1; bus.load_rd = 5'd5;
        tick();
        clear_inputs();
        bus.rs1_use = 1'b1; bus.rs1_addr = 5'd5;
        @(negedge clk);
        checks += 3;
        if (bus.hazard !== 1'b1) begin errors++; $display("FAIL lu_hazard got %b want 1", bus.hazard); end
        if (bus.stage_en !== 4'b1100) begin errors++; $display("FAIL lu_en got %b want 1100", bus.stage_en); end
        if (bus.pending[5] !== 1'b1) begin errors++; $display("FAIL lu_pending5 got %b want 1", bus.pending[5]); end
        bus.load_done = 1'b1; bus.load_done_rd = 5'd5;
        #1;
        checks += 2;
        if (bus.hazard !== 1'b0) begin errors++; $display("FAIL lu_bypass_hazard got %b want 0", bus.hazard); end
        if (bus.stage_en !== 4'b1111) begin errors++; $display("FAIL lu_bypass_en got %b want 1111", bus.stage_en); end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (bus.pending[5] !== 1'b0) begin errors++; $display("FAIL lu_cleared got %b want 0", bus.pending[5]); end
        tick();
        $display("test_load_use done");
    endtask

    task automatic test_set_wins();
        clear_inputs();
        bus.load_issue = 1'b1; bus.load_rd = 5'd7;
        tick();
        bus.load_done = 1'b1; bus.load_done_rd = 5'd7;
        tick();
        clear_inputs();
        @(negedge clk);
        checks += 2;
        if (bus.pending[7] !== 1'b1) begin errors++; $display("FAIL sw_pending7 got %b want 1", bus.pending[7]); end
        if (bus.load_block !== 1'b0) begin errors++; $display("FAIL sw_block got %b want 0", bus.load_block); end
        // One more accepted issue must reach the limit if the count stayed at 1
        bus.load_issue = 1'b1; bus.load_rd = 5'd9;
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (bus.load_block !== 1'b1) begin errors++; $display("FAIL sw_count got block %b want 1", bus.load_block); end
        bus.load_done = 1'b1; bus.load_done_rd = 5'd9;
        tick();
        bus.load_done_rd = 5'd7;
        tick();
        clear_inputs();
        @(negedge clk);
        checks += 2;
        if (bus.load_block !== 1'b0) begin errors++; $display("FAIL sw_drain_block got %b want 0", bus.load_block); end
        if (bus.pending !== 32'h0) begin errors++; $display("FAIL sw_drain_pending got %h want 0", bus.pending); end
        tick();
        $display("test_set_wins done");
    endtask

    task automatic test_load_limit();
        clear_inputs();
        bus.load_issue = 1'b1; bus.load_rd = 5'd3;
        tick();
        bus.load_rd = 5'd4;
        tick();
        clear_inputs();
        @(negedge clk);
        checks += 3;
        if (bus.load_block !== 1'b1) begin errors++; $display("FAIL ll_block got %b want 1", bus.load_block); end
        if (bus.stage_en !== 4'b1000) begin errors++; $display("FAIL ll_en got %b want 1000", bus.stage_en); end
        if (bus.bubble !== 4'b1000) begin errors++; $display("FAIL ll_bubble got %b want 1000", bus.bubble); end
        bus.load_issue = 1'b1; bus.load_rd = 5'd6;
        tick();
        clear_inputs();
        @(negedge clk);
        checks += 2;
        if (bus.pending[6] !== 1'b0) begin errors++; $display("FAIL ll_dropped got %b want 0", bus.pending[6]); end
        if (bus.pending !== 32'h0000_0018) begin errors++; $display("FAIL ll_pending got %h want 00000018", bus.pending); end
        bus.load_done = 1'b1; bus.load_done_rd = 5'd3;
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (bus.load_block !== 1'b0) begin errors++; $display("FAIL ll_release got %b want 0", bus.load_block); end
        bus.load_done = 1'b1; bus.load_done_rd = 5'd4;
        tick();
        clear_inputs();
        tick();
        $display("test_load_limit done");
    endtask

    task automatic test_watchdog();
        test_reset();
        bus.pause_req = 4'b0001;
        repeat (TO - 1) tick();
        @(negedge clk);
        checks++;
        if (bus.stall_timeout !== 1'b0) begin errors++; $display("FAIL wd_early got %b want 0", bus.stall_timeout); end
        tick();
        @(negedge clk);
        checks++;
        if (bus.stall_timeout !== 1'b1) begin errors++; $display("FAIL wd_trip got %b want 1", bus.stall_timeout); end
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (bus.perf_stall_cycles !== 32'd255) begin errors++; $display("FAIL wd_perf got %0d want 255", bus.perf_stall_cycles); end
`endif
        clear_inputs();
        tick();
        tick();
        @(negedge clk);
        checks += 2;
        if (bus.stall_timeout !== 1'b1) begin errors++; $display("FAIL wd_sticky got %b want 1", bus.stall_timeout); end
        if (bus.stage_en[0] !== 1'b1) begin errors++; $display("FAIL wd_release_en got %b want 1", bus.stage_en[0]); end
        test_reset();
        $display("test_watchdog done");
    endtask

    task automatic test_random();
        logic [3:0] e_en, e_fl, e_bub;
        logic e_haz, e_blk;
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 350) begin
                // Asynchronous reset in the middle of traffic
                rst = 1'b1;
                #1;
                checks += 2;
                if (bus.pending !== 32'h0) begin errors++; $display("FAIL rnd_async_pending n=%0d got %h want 0", n, bus.pending); end
                if (bus.load_block !== 1'b0) begin errors++; $display("FAIL rnd_async_block n=%0d got %b want 0", n, bus.load_block); end
                model_reset();
                tick();
                rst = 1'b0;
            end
            for (int k = 0; k < ST; k++) bus.pause_req[k] = ($urandom_range(0, 9) == 0);
            bus.flush_req    = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
            bus.rs1_use      = 1'($urandom);
            bus.rs1_addr     = 5'($urandom_range(0, 7));
            bus.rs2_use      = 1'($urandom);
            bus.rs2_addr     = 5'($urandom_range(0, 7));
            bus.load_issue   = ($urandom_range(0, 2) == 0);
            bus.load_rd      = 5'($urandom_range(0, 7));
            bus.load_done    = ($urandom_range(0, 2) == 0);
            bus.load_done_rd = 5'($urandom_range(0, 7));
            @(negedge clk);
            model_comb(e_en, e_fl, e_bub, e_haz, e_blk);
            checks += 7;
            if (bus.stage_en !== e_en) begin errors++; $display("FAIL rnd_en n=%0d got %b want %b", n, bus.stage_en, e_en); end
            if (bus.stage_flush !== e_fl) begin errors++; $display("FAIL rnd_flush n=%0d got %b want %b", n, bus.stage_flush, e_fl); end
            if (bus.bubble !== e_bub) begin errors++; $display("FAIL rnd_bubble n=%0d got %b want %b", n, bus.bubble, e_bub); end
            if (bus.hazard !== e_haz) begin errors++; $display("FAIL rnd_hazard n=%0d got %b want %b", n, bus.hazard, e_haz); end
            if (bus.load_block !== e_blk) begin errors++; $display("FAIL rnd_block n=%0d got %b want %b", n, bus.load_block, e_blk); end
            if (bus.pending !== m_pend) begin errors++; $display("FAIL rnd_pending n=%0d got %h want %h", n, bus.pending, m_pend); end
            if (bus.stall_timeout !== m_to) begin errors++; $display("FAIL rnd_timeout n=%0d got %b want %b", n, bus.stall_timeout, m_to); end
`ifdef PIPE_CTRL_PERF_EN
            checks += 2;
            if (bus.perf_stall_cycles !== m_perf_stall) begin errors++; $display("FAIL rnd_perf_stall n=%0d got %0d want %0d", n, bus.perf_stall_cycles, m_perf_stall); end
            if (bus.perf_flush_events !== m_perf_flush) begin errors++; $display("FAIL rnd_perf_flush n=%0d got %0d want %0d", n, bus.perf_flush_events, m_perf_flush); end
`endif
            tick();
        end
        clear_inputs();
        $display("test_random done");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_stall_flush();
        test_load_use();
        test_set_wins();
        test_load_limit();
        test_watchdog();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
